// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the codec I2C write master.
//   state_e            FSM states of i2c_write_master
//   Q0..Q3             quarter-phase encodings within one SCL period
//   NUM_BYTES_DEFAULT  bytes per write transaction (address + two register bytes)
//   CODEC_ADDR         codec 7-bit address with R/W=0, shared with the sequencer
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int NUM_BYTES_DEFAULT = 3;

  localparam logic [7:0] CODEC_ADDR = 8'h34;

endpackage

// File: rtl/i2c_write_master_if.sv
// i2c_write_master_if: request/handshake bundle between the codec
// configuration sequencer and the I2C write master, plus the SCL line.
//   start     request a transaction (sampled only while busy=0)
//   data      transaction bytes, most significant byte sent first
//   busy      transaction in progress
//   done      one-cycle completion pulse
//   ack       1 = every byte of the last transaction was ACKed
//   i2c_sclk  SCL, push-pull
// modport master: the I2C write master side; modport slave: the sequencer side.
interface i2c_write_master_if #(
  parameter int NUM_BYTES = i2c_pkg::NUM_BYTES_DEFAULT
);

  logic                   start;
  logic [8*NUM_BYTES-1:0] data;
  logic                   busy;
  logic                   done;
  logic                   ack;
  logic                   i2c_sclk;

  modport master (
    input  start,
    input  data,
    output busy,
    output done,
    output ack,
    output i2c_sclk
  );

  modport slave (
    output start,
    output data,
    input  busy,
    input  done,
    input  ack,
    input  i2c_sclk
  );

endinterface

// File: rtl/i2c_clk_divider.sv
// i2c_clk_divider: free-running 0..CLK_DIV-1 counter producing one
// quarter-SCL-period tick.
//   clk    system clock
//   reset  synchronous, active-high
//   clear  restart the count at 0 (transaction accepted)
//   tick   high while the count sits at CLK_DIV-1
module i2c_clk_divider #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(CLK_DIV - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/i2c_write_master.sv
// i2c_write_master: sends one fixed-length I2C write (NUM_BYTES bytes, MSB
// first) per accepted start, collects slave ACKs and reports pass/fail.
//   clk       system clock
//   reset     synchronous, active-high
//   bus       i2c_write_master_if.master (start, data, busy, done, ack, i2c_sclk)
//   i2c_sdat  SDA, open-drain: pulled low when sda_low_q=1, else high-Z
//
// Every bus state walks quarter phases Q0..Q3, one divider tick each.
//   state | meaning
//   IDLE  | SCL high, SDA released, waiting for start
//   START | start condition: SDA falls while SCL high, then SCL low
//   BIT   | one data bit: set SDA (Q0), SCL high (Q1,Q2), SCL low + shift (Q3)
//   ACK   | SDA released, slave ACK sampled at the end of Q2
//   STOP  | stop condition: SDA rises while SCL high
//   DONE  | single clk: done pulse, ack updated, back to IDLE
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 125,
  parameter int NUM_BYTES = NUM_BYTES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_write_master_if.master   bus,
  inout  wire                  i2c_sdat
);

  localparam int DW  = 8 * NUM_BYTES;
  localparam int BCW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            ack_acc_q, ack_acc_d;
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            div_clear;
  logic            tick;

  i2c_clk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_divider (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  assign i2c_sdat     = sda_low_q ? 1'b0 : 1'bz;
  assign bus.i2c_sclk = scl_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ack      = ack_q;

  // Outputs are registered: each tick loads SCL/SDA for the quarter being
  // entered, so the line levels hold for the full quarter.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ack_acc_d  = ack_acc_q;
    scl_d      = scl_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_d      = ack_q;
    div_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        if (bus.start) begin
          shift_d    = bus.data;
          ack_acc_d  = 1'b1;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          phase_d    = Q0;
          div_clear  = 1'b1;
          state_d    = START;
        end
      end

      START: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            Q0: sda_low_d = 1'b1;
            Q2: scl_d = 1'b0;
            Q3: begin
              state_d   = BIT;
              bit_cnt_d = 3'd7;
              sda_low_d = ~shift_q[DW-1];
            end
            default: ;
          endcase
        end
      end

      BIT: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            Q0: scl_d = 1'b1;
            Q2: begin
              scl_d   = 1'b0;
              shift_d = shift_q << 1;
            end
            Q3: begin
              if (bit_cnt_q == 3'd0) begin
                state_d   = ACK;
                sda_low_d = 1'b0;
              end else begin
                bit_cnt_d = bit_cnt_q - 3'd1;
                sda_low_d = ~shift_q[DW-1];
              end
            end
            default: ;
          endcase
        end
      end

      ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            Q0: scl_d = 1'b1;
            Q2: begin
              // Sampled just before SCL falls; a high line is a NACK.
              if (i2c_sdat) begin
                ack_acc_d = 1'b0;
              end
              scl_d = 1'b0;
            end
            Q3: begin
              if (int'(byte_cnt_q) < NUM_BYTES - 1) begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
                state_d    = BIT;
                bit_cnt_d  = 3'd7;
                sda_low_d  = ~shift_q[DW-1];
              end else begin
                state_d   = STOP;
                sda_low_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            Q0: scl_d = 1'b1;
            Q1: sda_low_d = 1'b0;
            Q3: begin
              state_d = DONE;
              done_d  = 1'b1;
              ack_d   = ack_acc_q;
            end
            default: ;
          endcase
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= Q0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      ack_acc_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ack_acc_q  <= ack_acc_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: directed bench for i2c_write_master with CLK_DIV=4.
// A driver issues transactions and pushes hand-computed expectations into a
// scoreboard queue; a negedge monitor decodes the bus, plays the slave (ACK or
// NACK per byte), checks protocol timing and compares at every done pulse.
module tb_i2c_write_master;
  import i2c_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int NB        = 3;
  localparam int TX_DONE   = 465;  // (4 + 3*36 + 4) quarters * 4 + 1
  localparam int START_OFS = 5;    // quarter 1 visible at 1*4 + 1
  localparam int STOP_OFS  = 457;  // quarter 114 visible at 114*4 + 1
  localparam int PHASES    = 55;   // 27 SCL periods * 2 edges + stop rise

  typedef struct {
    int          done_cyc;
    int          acc_cyc;
    logic        ack;
    logic [23:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slave_low = 1'b0;
  wire  sda;

  i2c_write_master_if bus ();

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_write_master #(
    .CLK_DIV   (CLK_DIV),
    .NUM_BYTES (NB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .i2c_sdat (sda)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / slave state
  logic        mon_en = 1'b0;
  logic [2:0]  nack_mask = 3'b000;
  logic        scl_s, sda_s;
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;
  logic        exp_ack_now = 1'b0;
  logic        busy_pending = 1'b0;
  logic [23:0] dec = '0;
  int          bitn = 0;
  int          byte_idx = NB;
  int          start_cnt = 0, stop_cnt = 0, start_cyc = 0, stop_cyc = 0;
  int          phase_cnt = 0, phase_err = 0, last_edge = -1;
  logic        in_xfer = 1'b0;
  int          spurious = 0;
  int          ack_hold_err = 0;
  exp_t        it;

  task automatic clear_stats();
    start_cnt = 0;
    stop_cnt  = 0;
    phase_cnt = 0;
    phase_err = 0;
    last_edge = -1;
    in_xfer   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      scl_s = bus.i2c_sclk;
      sda_s = sda;

      if (scl_p && scl_s && (sda_s !== sda_p)) begin
        if (sda_s == 1'b0) begin
          start_cnt++;
          start_cyc = cyc;
          in_xfer   = 1'b1;
          last_edge = -1;
          bitn      = 0;
          byte_idx  = 0;
          dec       = '0;
        end else begin
          stop_cnt++;
          stop_cyc = cyc;
          in_xfer  = 1'b0;
        end
      end

      if (scl_s !== scl_p) begin
        if (in_xfer) begin
          if (last_edge >= 0) begin
            phase_cnt++;
            if (cyc - last_edge != 2 * CLK_DIV) phase_err++;
          end
          last_edge = cyc;
        end
        if (byte_idx < NB) begin
          if (scl_s) begin
            if (bitn < 8) dec = {dec[22:0], sda_s};
            bitn++;
          end else if (bitn == 8) begin
            slave_low = ~nack_mask[byte_idx];
          end else if (bitn == 9) begin
            slave_low = 1'b0;
            bitn      = 0;
            byte_idx++;
          end
        end
      end

      if (rst_at_edge) exp_ack_now = 1'b0;

      if (busy_pending) begin
        busy_pending = 1'b0;
        chk("busy_after_done", bus.busy, 1'b0);
      end

      if (bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          spurious++;
        end else begin
          it = sbq.pop_front();
          chk("done_cycle", cyc, it.done_cyc);
          chk("ack", bus.ack, it.ack);
          chk("busy_in_done", bus.busy, 1'b1);
          chk("bytes", dec, it.data);
          chk("start_conds", start_cnt, 1);
          chk("stop_conds", stop_cnt, 1);
          chk("start_tick", start_cyc - it.acc_cyc, START_OFS);
          chk("stop_tick", stop_cyc - it.acc_cyc, STOP_OFS);
          chk("scl_phases", phase_cnt, PHASES);
          chk("scl_phase_len_err", phase_err, 0);
          exp_ack_now  = it.ack;
          busy_pending = 1'b1;
          clear_stats();
        end
      end

      if (bus.ack !== exp_ack_now) ack_hold_err++;

      scl_p = scl_s;
      sda_p = sda_s;
    end
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("tx_complete_pending", sbq.size(), 0);
    sbq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_tx(input logic [23:0] d, input logic [2:0] mask, input logic exp_ack);
    @(negedge clk);
    bus.data  = d;
    nack_mask = mask;
    bus.start = 1'b1;
    sbq.push_back('{done_cyc: cyc + TX_DONE, acc_cyc: cyc, ack: exp_ack, data: d});
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_cycle1", bus.busy, 1'b1);
    wait_idle(700);
  endtask

  initial begin
    int c0;
    bus.start = 1'b1;
    bus.data  = 24'hFFFFFF;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", bus.i2c_sclk, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy_with_start", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ack", bus.ack, 1'b0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
    mon_en = 1'b1;

    run_tx({CODEC_ADDR, 16'h0C10}, 3'b000, 1'b1);
    run_tx(24'h340C10, 3'b001, 1'b0);
    run_tx(24'h001201, 3'b000, 1'b1);
    run_tx(24'h340CFF, 3'b100, 1'b0);

    // start held through the first transfer and its done cycle
    @(negedge clk);
    c0        = cyc;
    bus.data  = 24'h340C10;
    nack_mask = 3'b000;
    bus.start = 1'b1;
    sbq.push_back('{done_cyc: c0 + TX_DONE, acc_cyc: c0, ack: 1'b1, data: 24'h340C10});
    sbq.push_back('{done_cyc: c0 + 466 + TX_DONE, acc_cyc: c0 + 466, ack: 1'b1, data: 24'h00ABCD});
    @(negedge clk);
    bus.data = 24'h00ABCD;
    while (cyc < c0 + 466) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(1200);

    // reset during byte 2, bit 5 (quarter 49, SCL high, SDA low)
    @(negedge clk);
    c0        = cyc;
    bus.data  = 24'h34C055;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < c0 + 198) @(negedge clk);
    chk("pre_rst_scl", bus.i2c_sclk, 1'b1);
    chk("pre_rst_sda", sda, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_scl", bus.i2c_sclk, 1'b1);
    chk("midrst_sda", sda, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    clear_stats();
    run_tx(24'h34C055, 3'b000, 1'b1);

    chk("no_spurious_done", spurious, 0);
    chk("ack_hold", ack_hold_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
